// File: rtl/fb_blit.sv
// fb_blit: SDRAM framebuffer rectangle copy client on one shared-arbiter port.
// Each burst is read into a local buffer, then written word by word to the destination row.
module fb_blit #(
   parameter int AN    = 24,
   parameter int DN    = 16,
   parameter int BURST = 8,
   parameter int LS    = 480,
   parameter int XW    = 9,
   parameter int YW    = 9
) (
   input  logic          clkSYS,
   input  logic          n_reset,
   input  logic          start,
   input  logic [AN-1:0] src_addr,
   input  logic [AN-1:0] dst_addr,
   input  logic [XW-1:0] width,
   input  logic [YW-1:0] height,
   output logic          busy,
   output logic          done,
   input  logic [DN-1:0] mem_data,
   input  logic          mem_valid,
   output logic [AN-1:0] req_addr,
   output logic [DN-1:0] req_data,
   output logic          req,
   output logic          req_wr,
   input  logic          req_ack,
   output logic [2:0]    dbg_state
);
   localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [XW:0]   C_BURST_X = (XW+1)'(BURST);
   localparam logic [XW:0]   C_ONE_X   = (XW+1)'(1);
   localparam logic [BW-1:0] C_LAST    = BW'(BURST-1);
   localparam logic [BW-1:0] C_ONE_B   = BW'(1);
   localparam logic [YW-1:0] C_ONE_Y   = YW'(1);
   localparam logic [AN-1:0] C_LS      = AN'(LS);

   typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_DATA, S_WR, S_NEXT, S_FIN} state_t;

   state_t        r_state, w_next;
   logic [AN-1:0] r_src_row, r_dst_row;
   logic [XW:0]   r_x;
   logic [YW-1:0] r_y;
   logic [XW-1:0] r_w;
   logic [YW-1:0] r_h;
   logic [BW-1:0] r_rcnt, r_wcnt;
   logic [DN-1:0] r_buf [BURST];

   logic [XW:0]   w_rem, w_n, w_x_next;
   logic [YW-1:0] w_y_next;
   logic [AN-1:0] w_x_ext, w_wcnt_ext;
   logic          w_rd_last, w_wr_last, w_row_more, w_last_row;

   // Only min(BURST, width-x) buffered words are written, so partial bursts stay inside the region.
   assign w_rem      = {1'b0, r_w} - r_x;
   assign w_n        = (w_rem < C_BURST_X) ? w_rem : C_BURST_X;
   assign w_wr_last  = ({{(XW+1-BW){1'b0}}, r_wcnt} == (w_n - C_ONE_X));
   assign w_rd_last  = (r_rcnt == C_LAST);
   assign w_x_next   = r_x + C_BURST_X;
   assign w_row_more = (w_x_next < {1'b0, r_w});
   assign w_y_next   = r_y + C_ONE_Y;
   assign w_last_row = (w_y_next == r_h);
   assign w_x_ext    = {{(AN-XW-1){1'b0}}, r_x};
   assign w_wcnt_ext = {{(AN-BW){1'b0}}, r_wcnt};

   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Handshake: req with req_addr/req_data/req_wr is held stable until a clock edge samples req_ack=1.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next = ((width == '0) || (height == '0)) ? S_FIN : S_RD_REQ;
         S_RD_REQ:  if (req_ack) w_next = S_RD_DATA;
         S_RD_DATA: if (mem_valid && w_rd_last) w_next = S_WR;
         S_WR:      if (req_ack && w_wr_last) w_next = S_NEXT;
         S_NEXT:    w_next = (w_row_more || !w_last_row) ? S_RD_REQ : S_FIN;
         S_FIN:     w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (r_state != S_IDLE) && (r_state != S_FIN);
      done     = (r_state == S_FIN);
      req      = (r_state == S_RD_REQ) || (r_state == S_WR);
      req_wr   = (r_state == S_WR);
      req_addr = '0;
      req_data = '0;
      if (r_state == S_RD_REQ) req_addr = r_src_row + w_x_ext;
      if (r_state == S_WR) begin
         req_addr = r_dst_row + w_x_ext + w_wcnt_ext;
         req_data = r_buf[r_wcnt];
      end
      dbg_state = r_state;
   end

   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) begin
         r_src_row <= '0;
         r_dst_row <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_w       <= '0;
         r_h       <= '0;
         r_rcnt    <= '0;
         r_wcnt    <= '0;
         for (int i = 0; i < BURST; i++) r_buf[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_src_row <= src_addr;
               r_dst_row <= dst_addr;
               r_w       <= width;
               r_h       <= height;
               r_x       <= '0;
               r_y       <= '0;
               r_rcnt    <= '0;
               r_wcnt    <= '0;
            end
            S_RD_DATA: if (mem_valid) begin
               r_buf[r_rcnt] <= mem_data;
               r_rcnt        <= w_rd_last ? '0 : r_rcnt + C_ONE_B;
            end
            S_WR: if (req_ack) r_wcnt <= w_wr_last ? '0 : r_wcnt + C_ONE_B;
            S_NEXT: begin
               if (w_row_more) begin
                  r_x <= w_x_next;
               end else begin
                  r_x       <= '0;
                  r_y       <= w_y_next;
                  r_src_row <= r_src_row + C_LS;
                  r_dst_row <= r_dst_row + C_LS;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fb_blit.sv
// Bench for fb_blit: arbiter/memory model with random stalls, a row/column copy model and directed jobs.
module tb_fb_blit;
   localparam int AN = 24, DN = 16, BURST = 8, LS = 480, XW = 9, YW = 9;

   logic          clkSYS = 1'b0;
   logic          n_reset = 1'b0;
   logic          start = 1'b0;
   logic [AN-1:0] src_addr = '0, dst_addr = '0;
   logic [XW-1:0] width = '0;
   logic [YW-1:0] height = '0;
   logic          busy, done;
   logic [DN-1:0] mem_data = '0;
   logic          mem_valid = 1'b0;
   logic [AN-1:0] req_addr;
   logic [DN-1:0] req_data;
   logic          req, req_wr;
   logic          req_ack = 1'b0;
   logic [2:0]    dbg_state;

   fb_blit dut (
      .clkSYS(clkSYS), .n_reset(n_reset), .start(start),
      .src_addr(src_addr), .dst_addr(dst_addr), .width(width), .height(height),
      .busy(busy), .done(done), .mem_data(mem_data), .mem_valid(mem_valid),
      .req_addr(req_addr), .req_data(req_data), .req(req), .req_wr(req_wr),
      .req_ack(req_ack), .dbg_state(dbg_state)
   );

   always #5 clkSYS = ~clkSYS;

   // Scoreboard: expected read addresses and {address, data} writes, in issue order.
   logic [AN-1:0]    exp_rd_q[$];
   logic [AN+DN-1:0] exp_wr_q[$];
   logic [AN+DN-1:0] wr_log[$];
   logic [AN+DN-1:0] ref_log[$];

   int n_checks = 0, n_pass = 0;
   int wr_acks = 0, rd_acks = 0, req_cycles = 0, done_cnt = 0, done_before = 0;
   int stall_left = 0, stall_hits = 0, rd_left = 0;
   bit stall_en = 1'b0, hold = 1'b0;
   logic [AN+DN:0]   held;
   logic [AN-1:0]    rd_base, rd_word, last_wr_addr;
   logic [DN-1:0]    last_wr_data;
   logic [AN+DN-1:0] e_wr;
   logic [AN-1:0]    e_rd;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
   endtask

   // Row-major copy: every word of the rectangle goes from src+y*LS+x to dst+y*LS+x.
   task automatic build_model(input logic [AN-1:0] s, input logic [AN-1:0] d, input int w, input int h);
      logic [AN-1:0] sa, da;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x += BURST) begin
            sa = s + AN'(y*LS + x);
            exp_rd_q.push_back(sa);
         end
         for (int x = 0; x < w; x++) begin
            sa = s + AN'(y*LS + x);
            da = d + AN'(y*LS + x);
            exp_wr_q.push_back({da, sa[DN-1:0]});
         end
      end
   endtask

   // Arbiter + memory: returns the word address as data, checks every accepted request.
   always @(negedge clkSYS) begin
      if (!n_reset) begin
         mem_valid  = 1'b0;
         req_ack    = 1'b0;
         rd_left    = 0;
         hold       = 1'b0;
         stall_left = 0;
      end else begin
         if (rd_left > 0 && (!stall_en || $urandom_range(0, 2) != 0)) begin
            rd_word   = rd_base + AN'(BURST - rd_left);
            mem_valid = 1'b1;
            mem_data  = rd_word[DN-1:0];
            rd_left--;
         end else if (stall_en && rd_left == 0 && $urandom_range(0, 3) == 0) begin
            mem_valid = 1'b1;
            mem_data  = 16'hdead;
         end else begin
            mem_valid = 1'b0;
         end
         if (req) begin
            req_cycles++;
            if (hold) check("held request stable", {req_wr, req_addr, req_data}, held);
            if (stall_left > 0) begin
               req_ack = 1'b0;
               stall_left--;
               stall_hits++;
               hold = 1'b1;
               held = {req_wr, req_addr, req_data};
            end else begin
               req_ack = 1'b1;
               hold    = 1'b0;
               if (req_wr) begin
                  if (exp_wr_q.size() == 0) check("unexpected write", 1, 0);
                  else begin
                     e_wr = exp_wr_q.pop_front();
                     check("write addr", req_addr, e_wr[AN+DN-1:DN]);
                     check("write data", req_data, e_wr[DN-1:0]);
                  end
                  wr_log.push_back({req_addr, req_data});
                  last_wr_addr = req_addr;
                  last_wr_data = req_data;
                  wr_acks++;
               end else begin
                  if (exp_rd_q.size() == 0) check("unexpected read", 1, 0);
                  else begin
                     e_rd = exp_rd_q.pop_front();
                     check("read addr", req_addr, e_rd);
                  end
                  rd_base = req_addr;
                  rd_left = BURST;
                  rd_acks++;
               end
               stall_left = stall_en ? $urandom_range(0, 7) : 0;
            end
         end else begin
            req_ack = 1'b0;
            hold    = 1'b0;
         end
      end
   end

   always @(negedge clkSYS) if (done) done_cnt++;

   task automatic go(input logic [AN-1:0] s, input logic [AN-1:0] d, input int w, input int h);
      @(negedge clkSYS);
      src_addr = s; dst_addr = d; width = XW'(w); height = YW'(h);
      start = 1'b1;
      done_before = done_cnt;
      @(negedge clkSYS);
      start = 1'b0;
      if (w == 0 || h == 0) begin
         check("empty job done next cycle", done, 1);
         check("empty job never busy", busy, 0);
      end else begin
         check("busy after start", busy, 1);
         check("no early done", done, 0);
      end
   endtask

   task automatic wait_done(input bit extra);
      int cyc = 0;
      while (!done && cyc < 5000) begin
         @(negedge clkSYS);
         cyc++;
         if (extra && !done && (cyc == 2 || cyc == 5 || cyc == 9)) begin
            start = 1'b1; src_addr = 24'h000555; dst_addr = 24'h000777; width = 3; height = 3;
         end else start = 1'b0;
      end
      start = 1'b0;
      check("done within budget", cyc < 5000, 1);
      check("busy low with done", busy, 0);
      repeat (3) @(negedge clkSYS);
      check("single done pulse", done_cnt - done_before, 1);
      check("reads consumed", exp_rd_q.size(), 0);
      check("writes consumed", exp_wr_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc, r0, w0, q0, same;
      repeat (3) @(negedge clkSYS);
      check("reset req", req, 0);
      check("reset req_wr", req_wr, 0);
      check("reset req_addr", req_addr, 0);
      check("reset req_data", req_data, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset state idle", dbg_state, 0);
      @(posedge clkSYS); #2 n_reset = 1'b1;

      // Abort a copy in the middle of its write burst.
      w0 = wr_acks;
      build_model(24'h000040, 24'h000300, 8, 1);
      go(24'h000040, 24'h000300, 8, 1);
      cyc = 0;
      while (wr_acks < w0 + 3 && cyc < 1000) begin @(posedge clkSYS); cyc++; end
      check("reached write burst", cyc < 1000, 1);
      #2 n_reset = 1'b0;
      #1;
      check("req dropped in reset", req, 0);
      check("busy dropped in reset", busy, 0);
      exp_rd_q.delete(); exp_wr_q.delete();
      repeat (3) @(negedge clkSYS);
      check("no done after abort", done_cnt - done_before, 0);
      @(posedge clkSYS); #2 n_reset = 1'b1;
      build_model(24'h000000, 24'h000100, 8, 1);
      go(24'h000000, 24'h000100, 8, 1);
      wait_done(1'b0);
      check("post-abort last addr", last_wr_addr, 24'h000107);
      check("post-abort last data", last_wr_data, 16'h0007);

      // Empty region: immediate done, no requests.
      q0 = req_cycles;
      go(24'h001000, 24'h002000, 0, 5);
      wait_done(1'b0);
      check("empty job issues no req", req_cycles - q0, 0);

      // Two rows of 16 words, stall-free.
      build_model(24'h000000, 24'h000100, 16, 2);
      check("model read 2", exp_rd_q[2], 24'h0001e0);
      check("model read 3", exp_rd_q[3], 24'h0001e8);
      check("model write 16", exp_wr_q[16], {24'h0002e0, 16'h01e0});
      check("model write 31", exp_wr_q[31], {24'h0002ef, 16'h01ef});
      wr_log.delete();
      r0 = rd_acks;
      go(24'h000000, 24'h000100, 16, 2);
      wait_done(1'b0);
      check("16x2 read count", rd_acks - r0, 4);
      check("16x2 last addr", last_wr_addr, 24'h0002ef);
      check("16x2 last data", last_wr_data, 16'h01ef);
      ref_log = wr_log;

      // Same copy with arbiter stalls and memory gaps.
      stall_en = 1'b1;
      wr_log.delete();
      build_model(24'h000000, 24'h000100, 16, 2);
      go(24'h000000, 24'h000100, 16, 2);
      wait_done(1'b0);
      stall_en = 1'b0;
      check("stalled write count", wr_log.size(), ref_log.size());
      same = 1;
      for (int i = 0; i < wr_log.size() && i < ref_log.size(); i++)
         if (wr_log[i] !== ref_log[i]) same = 0;
      check("stalled sequence matches", same, 1);
      check("stalls exercised", stall_hits > 0, 1);

      // Partial burst: 5 of 8 buffered words written.
      r0 = rd_acks; w0 = wr_acks;
      build_model(24'h001000, 24'h002000, 5, 1);
      go(24'h001000, 24'h002000, 5, 1);
      wait_done(1'b0);
      check("w5 read count", rd_acks - r0, 1);
      check("w5 write count", wr_acks - w0, 5);
      check("w5 last addr", last_wr_addr, 24'h002004);
      check("w5 last data", last_wr_data, 16'h1004);

      // Address wrap with starts pulsed while busy.
      build_model(24'hfffffc, 24'hfffffe, 12, 1);
      check("model wrap read", exp_rd_q[1], 24'h000004);
      check("model wrap write", exp_wr_q[2], {24'h000000, 16'hfffe});
      go(24'hfffffc, 24'hfffffe, 12, 1);
      wait_done(1'b1);
      check("wrap last addr", last_wr_addr, 24'h000009);
      check("wrap last data", last_wr_data, 16'h0007);
      repeat (5) @(negedge clkSYS);
      check("extra starts ignored", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fb_blit.md
Name: fb_blit

Overview:
- Memory-arbiter client that copies a rectangular pixel region between two locations of the SDRAM framebuffer (line stride LS words).
- Sits on one port of the shared SDRAM arbiter, alongside the TFT, PPU framebuffer, rectangle fill and memory test clients.
- Reads one burst into a local BURST-word buffer, then writes it back word by word to the destination.
- Used for scrolling and for moving the PPU window inside the TFT frame.

Parameters:
- AN, 24, address width in words.
- DN, 16, data width (RGB565 pixel).
- BURST, 8, words returned per read request; also the local buffer depth.
- LS, 480, framebuffer line stride in words.
- XW, 9, width of the width operand.
- YW, 9, width of the height operand.

Ports:
- clkSYS  in  1  system clock; all logic is in this domain.
- n_reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches the operands below when idle.
- src_addr  in  AN  source top-left word address.
- dst_addr  in  AN  destination top-left word address.
- width  in  XW  region width in words.
- height  in  YW  region height in lines.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the copy completes.
- mem_data  in  DN  shared arbiter read data.
- mem_valid  in  1  read word valid for this client.
- req_addr  out  AN  request address.
- req_data  out  DN  write data.
- req  out  1  request to arbiter.
- req_wr  out  1  1 = write, 0 = read.
- req_ack  in  1  arbiter accepted the current request.

Behaviour:
- Reset: busy=0, done=0, req=0, req_wr=0, req_addr=0, req_data=0; FSM returns to IDLE; buffer and counters are cleared. Reset mid-operation abandons the copy, drops req immediately and produces no done pulse.
- States: IDLE, RD_REQ, RD_DATA, WR, NEXT, FIN.
- IDLE:
  - On start, latch all operands and set the row pointers to src_addr and dst_addr, with x=0 and y=0.
  - If width==0 or height==0, go to FIN; no requests are issued.
  - Otherwise go to RD_REQ.
  - start is ignored in every state other than IDLE.
- RD_REQ:
  - Drive req=1, req_wr=0, req_addr=src_row+x.
  - Hold these until the cycle req_ack=1, then go to RD_DATA with req=0 on the next cycle.
- RD_DATA:
  - Each mem_valid cycle stores mem_data into buffer[rcnt] and increments rcnt.
  - After BURST words, go to WR.
  - mem_valid in any other state is ignored.
- WR:
  - Drive req=1, req_wr=1, req_addr=dst_row+x+wcnt, req_data=buffer[wcnt].
  - Each req_ack advances wcnt. Address and data update the cycle after ack, and req stays high between consecutive words.
  - The words written in this burst are n=min(BURST, width-x). After n acks, drop req and go to NEXT.
  - The rest of the burst buffer is discarded, so a width that is not a multiple of BURST never writes past the region.
- NEXT:
  - x+=BURST.
  - If x<width, go to RD_REQ.
  - Otherwise set x=0, y+=1, src_row+=LS, dst_row+=LS. If y==height go to FIN, else go to RD_REQ.
- FIN: done=1 for exactly one cycle, busy=0 on the same cycle, then IDLE.
- Arithmetic: all address sums are modulo 2^AN (wrap-around permitted, no error). x is XW+1 bits so that x+BURST never overflows.
- Overlap: copies run row-ascending and column-ascending. An overlapping copy with dst>src and dst<src+span is undefined; software must order such copies.
- Latency: per burst, at least 1 cycle for read ack, then BURST valid cycles, then n write acks, plus 1 NEXT cycle. The arbiter sets the actual timing.

Test Plan:
- Reset during WR mid-burst, then release:
  - req=0 and busy=0 immediately, no done pulse.
  - A following start with src=0, dst=0x100, width=8, height=1 completes normally.
- width=0, height=5: done one cycle after the start cycle; req never asserted.
- src=0x000000, dst=0x000100, width=16, height=2, arbiter acks in 1 cycle, memory returns src address as data:
  - Reads are issued at 0x0, 0x8, 0x1E0 and 0x1E8.
  - Writes cover 0x100–0x10F with data 0x0–0xF, and 0x2E0–0x2EF with data 0x1E0–0x1EF.
  - Exactly one done pulse.
- width=5, height=1, BURST=8:
  - One read of 8 words.
  - Exactly 5 write acks, to dst..dst+4.
  - The remaining 3 buffered words are never written.
- Random req_ack stalls of 0–7 cycles and gaps in mem_valid:
  - The written data sequence is identical to the stall-free run.
  - req_addr and req_data are stable while req=1 and req_ack=0.
- start pulses while busy, and src_addr near 2^24-4:
  - Extra starts are ignored.
  - Addresses wrap to 0x000000 without error.
